// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - E-stage multiply/divide unit owning HI/LO, with busy sequencing and D-stage stall request
// Optional: define MDU_DIVZERO_HOLD_EN to make divide-by-zero a 1-cycle no-op on HI/LO.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_data
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_wr;

  logic          long_op;
  logic [63:0]   sprod;
  logic [63:0]   uprod;
  logic [31:0]   a_mag, b_mag, b_safe, b_safe_u;
  logic [31:0]   sq_mag, sr_mag, uq, ur;
  logic [31:0]   res_hi, res_lo;
  logic          res_wr;
  logic [CW-1:0] res_cnt;

  assign long_op  = (mdop == OP_MULT) || (mdop == OP_MULTU) ||
                    (mdop == OP_DIV)  || (mdop == OP_DIVU);
  assign stall_md = d_is_md && (busy || (start && long_op));

  assign sprod = $signed(a) * $signed(b);
  assign uprod = {32'h0, a} * {32'h0, b};

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0 naturally.
  assign a_mag    = a[31] ? (~a + 32'd1) : a;
  assign b_mag    = b[31] ? (~b + 32'd1) : b;
  assign b_safe   = (b == 32'h0) ? 32'd1 : b_mag;
  assign b_safe_u = (b == 32'h0) ? 32'd1 : b;
  assign sq_mag   = a_mag / b_safe;
  assign sr_mag   = a_mag % b_safe;
  assign uq       = a / b_safe_u;
  assign ur       = a % b_safe_u;

  always_comb begin
    res_hi  = 32'h0;
    res_lo  = 32'h0;
    res_wr  = 1'b1;
    res_cnt = CW'(MULT_CYCLES - 1);
    case (mdop)
      OP_MULT: begin
        res_hi = sprod[63:32];
        res_lo = sprod[31:0];
      end
      OP_MULTU: begin
        res_hi = uprod[63:32];
        res_lo = uprod[31:0];
      end
      OP_DIV, OP_DIVU: begin
        res_cnt = CW'(DIV_CYCLES - 1);
        if (b == 32'h0) begin
`ifdef MDU_DIVZERO_HOLD_EN
          res_cnt = '0;
          res_wr  = 1'b0;
`else
          res_hi  = a;
          res_lo  = 32'hFFFF_FFFF;
`endif
        end else if (mdop == OP_DIV) begin
          res_lo = (a[31] ^ b[31]) ? (~sq_mag + 32'd1) : sq_mag;
          res_hi = a[31] ? (~sr_mag + 32'd1) : sr_mag;
        end else begin
          res_lo = uq;
          res_hi = ur;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= 32'h0;
      lo      <= 32'h0;
      pend_hi <= 32'h0;
      pend_lo <= 32'h0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && long_op) begin
            state   <= BUSY;
            busy    <= 1'b1;
            cnt     <= res_cnt;
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= res_wr;
          end else if (start && mdop == OP_MTHI) begin
            hi <= a;
          end else if (start && mdop == OP_MTLO) begin
            lo <= a;
          end
        end
        BUSY: begin
          // Starts arriving here are protocol violations and are dropped.
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mf_data = 32'h0;
    if (mdop == OP_MFHI)      mf_data = hi;
    else if (mdop == OP_MFLO) mf_data = lo;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - scoreboard bench for mdu_ctrl with directed vectors
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic        d_is_md;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mf_data;

  typedef struct {
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_cyc;
  } sb_t;

  sb_t sb_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mdop     (mdop),
    .a        (a),
    .b        (b),
    .d_is_md  (d_is_md),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo),
    .mf_data  (mf_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: a busy falling edge (outside reset) is a completed operation.
  initial begin
    logic prev_busy;
    int   cyc;
    sb_t  e;
    prev_busy = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        prev_busy = 1'b0;
        cyc = 0;
      end else begin
        if (busy) cyc++;
        else if (prev_busy) begin
          if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_completion actual=1 expected=0");
          end else begin
            e = sb_q.pop_front();
            chk("result_hi", hi, e.exp_hi);
            chk("result_lo", lo, e.exp_lo);
            chk("busy_cycles", 32'(cyc), 32'(e.exp_cyc));
          end
          cyc = 0;
        end
        prev_busy = busy;
      end
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el, input int ec);
    sb_t e;
    int  waited;
    logic stall_bad;
    e.exp_hi = eh;
    e.exp_lo = el;
    e.exp_cyc = ec;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b1; mdop = op; a = av; b = bv; d_is_md = 1'b1;
    @(negedge clk);
    chk("stall_at_start", {31'h0, stall_md}, 32'h1);
    @(posedge clk); #1;
    start = 1'b0; mdop = 4'd0;
    stall_bad = 1'b0;
    waited = 0;
    while (busy && waited < 100) begin
      @(negedge clk);
      if (busy && !stall_md) stall_bad = 1'b1;
      waited++;
    end
    chk("busy_timeout", {31'h0, busy}, 32'h0);
    chk("stall_while_busy", {31'h0, stall_bad}, 32'h0);
    chk("stall_after_done", {31'h0, stall_md}, 32'h0);
    d_is_md = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; mdop = 4'd0; a = 32'h0; b = 32'h0; d_is_md = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_stall", {31'h0, stall_md}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run_op(4'd4, 32'd7,         32'd2,         32'd1,         32'd3,         10);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 10);

    // MTHI then MFHI, MTLO then MFLO: single-edge writes, never busy
    @(posedge clk); #1;
    start = 1'b1; mdop = 4'd5; a = 32'h1234_5678; d_is_md = 1'b1;
    @(negedge clk);
    chk("mthi_no_stall", {31'h0, stall_md}, 32'h0);
    @(posedge clk); #1;
    mdop = 4'd7; a = 32'h0;
    @(negedge clk);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mfhi_data", mf_data, 32'h1234_5678);
    chk("mthi_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    mdop = 4'd6; a = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mdop = 4'd8; a = 32'h0;
    @(negedge clk);
    chk("mtlo_lo", lo, 32'hCAFE_F00D);
    chk("mflo_data", mf_data, 32'hCAFE_F00D);
    chk("mtlo_busy", {31'h0, busy}, 32'h0);
    start = 1'b0; mdop = 4'd0; d_is_md = 1'b0;
    #1;
    chk("mf_none", mf_data, 32'h0);

`ifdef MDU_DIVZERO_HOLD_EN
    run_op(4'd3, 32'd5, 32'd0, 32'h1234_5678, 32'hCAFE_F00D, 1);
`else
    run_op(4'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 10);
`endif

    // Reset in the middle of a DIV: immediate clear, no late write afterwards
    @(posedge clk); #1;
    start = 1'b1; mdop = 4'd3; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; mdop = 4'd0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy", {31'h0, busy}, 32'h0);
    chk("async_rst_hi", hi, 32'h0);
    chk("async_rst_lo", lo, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_rst_busy", {31'h0, busy}, 32'h0);
    chk("post_rst_hi", hi, 32'h0);
    chk("post_rst_lo", lo, 32'h0);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multiply/divide unit with its own sequencing controller, sitting in the E stage of the 5-stage pipeline beside the ALU.
- Accepts one HI/LO-class operation per start pulse and owns the HI and LO registers.
- Models multi-cycle mult/div latency with a busy counter.
- Raises a stall request so the D stage holds any HI/LO-class instruction until the unit is free.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥1)
DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  valid HI/LO-class instruction in E stage this cycle
mdop  input  4  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, others NONE
a  input  32  rs operand (forwarded)
b  input  32  rt operand (forwarded)
d_is_md  input  1  D-stage instruction is any of ops 1..8
busy  output  1  long operation in flight
stall_md  output  1  stall request to the hazard unit
hi  output  32  HI register
lo  output  32  LO register
mf_data  output  32  hi when mdop==MFHI, lo when mdop==MFLO, else 0 (combinational)

Behaviour:
- Reset (reset==0, async): state IDLE, counter 0, busy 0, hi 0, lo 0, pending results discarded. This holds even mid-operation.
- States:
  - IDLE: start && mdop in {1..4} → BUSY. Operands are latched and the result is computed into pending_hi/pending_lo at that edge. Counter loads MULT_CYCLES-1 or DIV_CYCLES-1.
  - BUSY: counter decrements each edge. On the edge where counter==0, hi/lo take the pending values, busy falls and state returns to IDLE.
- Latency: the op is sampled at edge k. busy is 1 from edge k to edge k+N, where N is the selected cycle count. New hi/lo are visible after edge k+N.
- MTHI/MTLO in IDLE: write a into hi/lo at the sampling edge. busy stays 0.
- MFHI/MFLO are pure reads via mf_data. No state change.
- Any start while BUSY is ignored; no state change. This is a protocol violation that stall_md prevents.
- stall_md = d_is_md && (busy || (start && mdop in {1..4})).
- mult: signed 64-bit product, HI=[63:32], LO=[31:0]. multu: unsigned product, same split.
- div: quotient truncates toward zero, into LO. Remainder takes the sign of the dividend, into HI.
- div with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- divu: unsigned quotient into LO, remainder into HI.
- Divide by zero, without the optional feature: full DIV_CYCLES latency, then LO=0xFFFFFFFF and HI=a.
- Counter width is at least $clog2(max(MULT_CYCLES, DIV_CYCLES))+1.

Optional Feature:
- Macro: MDU_DIVZERO_HOLD_EN.
- Defined: div/divu with b==0 takes exactly 1 busy cycle and leaves hi/lo unchanged.
- Undefined: divide-by-zero behaves as described in Behaviour (full latency, LO=0xFFFFFFFF, HI=a).

Test Plan:
- Reset, then MULT a=0xFFFFFFFE (-2), b=3:
  - busy high for 5 cycles.
  - After the 5th edge, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - With d_is_md=1 throughout, stall_md is high from the start cycle until busy falls.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7, b=2 → lo=3, hi=1.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0x12345678, then MFHI the next cycle → hi and mf_data = 0x12345678 after one edge; busy never asserted.
- Start DIV, assert reset at busy cycle 4:
  - busy=0 and hi=lo=0 immediately (asynchronously).
  - After reset release, no late write occurs.
- Divide by zero with a=5, b=0:
  - Macro undefined: 10 busy cycles, then lo=0xFFFFFFFF, hi=5.
  - Macro defined: 1 busy cycle, hi/lo keep their prior values.
